// File: rtl/pipe_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_stage
// Description : Registered decode/control stage between IF/ID and EX.
//               Decodes the RV32 opcode into the control bundle and registers
//               it behind a valid/ready handshake. It also inserts a single
//               bubble on a load-use hazard, handles flush, flags illegal
//               opcodes, and holds off issue while an M-extension op
//               occupies EX.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stage #(
    parameter int REG_ADDR_W  = 5,
    parameter int ENABLE_M    = 1,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic                  flush,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  can_branch,
    output logic                  mem_read,
    output logic                  mem_to_reg,
    output logic                  mem_write,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  should_jump,
    output logic [1:0]            alu_op,
    output logic                  is_mop,
    output logic                  illegal,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd
);

    // RV32 major opcodes
    localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OP_STORE   = 7'b0100011;
    localparam logic [6:0] c_OP_JAL     = 7'b1101111;
    localparam logic [6:0] c_OP_JALR    = 7'b1100111;
    localparam logic [6:0] c_OP_ARITH_I = 7'b0010011;
    localparam logic [6:0] c_OP_ARITH_R = 7'b0110011;
    localparam logic [6:0] c_OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OP_LUI     = 7'b0110111;
    localparam logic [6:0] c_FUNCT7_M   = 7'b0000001;

    // Issue state machine
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_MWAIT = 1'b1;

    // Hold counter sized for MUL_LATENCY-1 (at least one bit)
    localparam bit              c_HAS_WAIT = (MUL_LATENCY > 1);
    localparam int              c_CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MUL_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Bundle bit positions: {br, mr, m2r, mw, src, rw, jmp, aluop[1:0], mop, ill}
    localparam int c_BIT_MOP = 1;

    logic [6:0]            w_opcode;
    logic [6:0]            w_funct7;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [10:0]           w_dec;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic                  w_hazard;
    logic                  w_upd;
    logic                  w_accept;
    logic                  w_bubble;
    logic                  w_mop_leave;
    logic                  w_unused_funct3;

    logic [0:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_out_valid;
    logic [10:0]           r_bundle;
    logic                  r_bubble_sent;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;

    assign w_opcode        = instr[6:0];
    assign w_funct7        = instr[31:25];
    assign w_rd            = REG_ADDR_W'(instr[11:7]);
    assign w_rs1           = REG_ADDR_W'(instr[19:15]);
    assign w_rs2           = REG_ADDR_W'(instr[24:20]);
    assign w_unused_funct3 = ^instr[14:12];

    // Opcode decode into the control bundle plus operand-use flags
    always_comb begin
        w_dec     = '0;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            c_OP_BRANCH: begin
                w_dec     = 11'b1000000_01_00;
                w_use_rs2 = 1'b1;
            end
            c_OP_LOAD:    w_dec = 11'b0110110_00_00;
            c_OP_STORE: begin
                w_dec     = 11'b0001100_00_00;
                w_use_rs2 = 1'b1;
            end
            c_OP_JAL: begin
                w_dec     = 11'b0000111_00_00;
                w_use_rs1 = 1'b0;
            end
            c_OP_JALR:    w_dec = 11'b0000111_00_00;
            c_OP_ARITH_I: w_dec = 11'b0000110_11_00;
            c_OP_ARITH_R: begin
                w_dec            = 11'b0000010_10_00;
                w_dec[c_BIT_MOP] = (ENABLE_M != 0) && (w_funct7 == c_FUNCT7_M);
                w_use_rs2        = 1'b1;
            end
            c_OP_AUIPC, c_OP_LUI: begin
                w_dec     = 11'b0000110_00_00;
                w_use_rs1 = 1'b0;
            end
            default:      w_dec = 11'b0000000_00_01;
        endcase
    end

    // Load-use hazard against the load currently in EX (x0 never hazards)
    assign w_hazard = ex_mem_read && (ex_rd != '0) &&
                      ((w_use_rs1 && (ex_rd == w_rs1)) || (w_use_rs2 && (ex_rd == w_rs2)));

    assign w_upd       = !r_out_valid || out_ready;
    assign in_ready    = (r_state == c_ST_RUN) && !w_hazard && w_upd;
    assign w_accept    = in_valid && in_ready && !flush;
    // Only one bubble per hazard episode; the held instr waits upstream after that
    assign w_bubble    = in_valid && w_hazard && (r_state == c_ST_RUN) && !r_bubble_sent;
    assign w_mop_leave = r_out_valid && out_ready && r_bundle[c_BIT_MOP];

    // Output register: decoded bundle, bubble, or empty; flush kills regardless of stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_bundle      <= '0;
            r_bubble_sent <= 1'b0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
            r_bubble_sent <= 1'b0;
        end else if (w_upd) begin
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_bundle      <= w_dec;
                r_bubble_sent <= 1'b0;
                r_rs1         <= w_rs1;
                r_rs2         <= w_rs2;
                r_rd          <= w_rd;
            end else if (w_bubble) begin
                r_out_valid   <= 1'b1;
                r_bundle      <= '0;
                r_bubble_sent <= 1'b1;
            end else begin
                r_out_valid   <= 1'b0;
                r_bubble_sent <= r_bubble_sent && in_valid && w_hazard;
            end
        end
    end

    // Issue FSM: hold off new issue while an M-op occupies EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else if (c_HAS_WAIT && w_mop_leave) begin
            r_state <= c_ST_MWAIT;
            r_cnt   <= c_CNT_INIT;
        end else if (r_state == c_ST_MWAIT) begin
            if (r_cnt == c_CNT_ONE) begin
                r_state <= c_ST_RUN;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign can_branch  = r_bundle[10];
    assign mem_read    = r_bundle[9];
    assign mem_to_reg  = r_bundle[8];
    assign mem_write   = r_bundle[7];
    assign alu_src     = r_bundle[6];
    assign reg_write   = r_bundle[5];
    assign should_jump = r_bundle[4];
    assign alu_op      = r_bundle[3:2];
    assign is_mop      = r_bundle[1];
    assign illegal     = r_bundle[0];
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_stage
// Description : Self-checking bench for pipe_ctrl_stage. A decode table is
//               streamed through two instances (M enabled / disabled), then
//               hand sequences cover load-use, M-op hold, backpressure, flush
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_stage;

    localparam int AW = 5;

    // Expected bundles {br, mr, m2r, mw, src, rw, jmp, aluop, mop, ill}
    localparam logic [10:0] K_BR  = 11'b1000000_01_00;
    localparam logic [10:0] K_LD  = 11'b0110110_00_00;
    localparam logic [10:0] K_ST  = 11'b0001100_00_00;
    localparam logic [10:0] K_JMP = 11'b0000111_00_00;
    localparam logic [10:0] K_AI  = 11'b0000110_11_00;
    localparam logic [10:0] K_AR  = 11'b0000010_10_00;
    localparam logic [10:0] K_MUL = 11'b0000010_10_10;
    localparam logic [10:0] K_UI  = 11'b0000110_00_00;
    localparam logic [10:0] K_ILL = 11'b0000000_00_01;
    localparam logic [10:0] K_NOP = 11'b0000000_00_00;

    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2,4(x1)
    localparam logic [31:0] I_ADD  = 32'h006281B3;  // add  x3,x5,x6
    localparam logic [31:0] I_MUL  = 32'h022083B3;  // mul  x7,x1,x2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, flush, ex_mem_read, out_ready;
    logic [31:0]   instr;
    logic [AW-1:0] ex_rd;

    logic          in_ready, out_valid, can_branch, mem_read, mem_to_reg, mem_write;
    logic          alu_src, reg_write, should_jump, is_mop, illegal;
    logic [1:0]    alu_op;
    logic [AW-1:0] rs1, rs2, rd;

    logic          nm_in_ready, nm_out_valid, nm_can_branch, nm_mem_read, nm_mem_to_reg;
    logic          nm_mem_write, nm_alu_src, nm_reg_write, nm_should_jump, nm_is_mop, nm_illegal;
    logic [1:0]    nm_alu_op;
    logic [AW-1:0] nm_rs1, nm_rs2, nm_rd;

    logic [10:0] bundle, nm_bundle;
    assign bundle    = {can_branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
                        should_jump, alu_op, is_mop, illegal};
    assign nm_bundle = {nm_can_branch, nm_mem_read, nm_mem_to_reg, nm_mem_write, nm_alu_src,
                        nm_reg_write, nm_should_jump, nm_alu_op, nm_is_mop, nm_illegal};

    pipe_ctrl_stage #(.REG_ADDR_W(AW), .ENABLE_M(1), .MUL_LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .out_valid(out_valid),
        .out_ready(out_ready), .can_branch(can_branch), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .should_jump(should_jump), .alu_op(alu_op), .is_mop(is_mop),
        .illegal(illegal), .rs1(rs1), .rs2(rs2), .rd(rd)
    );

    pipe_ctrl_stage #(.REG_ADDR_W(AW), .ENABLE_M(0), .MUL_LATENCY(3)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nm_in_ready), .instr(instr),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .out_valid(nm_out_valid),
        .out_ready(out_ready), .can_branch(nm_can_branch), .mem_read(nm_mem_read),
        .mem_to_reg(nm_mem_to_reg), .mem_write(nm_mem_write), .alu_src(nm_alu_src),
        .reg_write(nm_reg_write), .should_jump(nm_should_jump), .alu_op(nm_alu_op),
        .is_mop(nm_is_mop), .illegal(nm_illegal), .rs1(nm_rs1), .rs2(nm_rs2), .rd(nm_rd)
    );

    typedef struct {
        logic [31:0] ins;
        logic [10:0] exp;
        logic [10:0] exp_nm;
    } vec_t;

    typedef struct {
        logic [10:0] b;
        logic [14:0] r;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] regs_of(input logic [31:0] ins);
        return {ins[11:7], ins[19:15], ins[24:20]};
    endfunction

    task automatic push_exp(input logic [10:0] b, input logic [31:0] ins);
        exp_t e;
        e.b = b;
        e.r = regs_of(ins);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, "_bundle"}, {21'd0, bundle}, {21'd0, e.b});
            chk({nm, "_regs"}, {17'd0, rd, rs1, rs2}, {17'd0, e.r});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h00500093, K_AI,  K_AI};   // addi
        vecs[1]  = '{32'h0000A103, K_LD,  K_LD};   // lw
        vecs[2]  = '{32'h0020A223, K_ST,  K_ST};   // sw
        vecs[3]  = '{32'h00208463, K_BR,  K_BR};   // beq
        vecs[4]  = '{32'h010000EF, K_JMP, K_JMP};  // jal
        vecs[5]  = '{32'h00008067, K_JMP, K_JMP};  // jalr
        vecs[6]  = '{32'h006281B3, K_AR,  K_AR};   // add
        vecs[7]  = '{32'h40A48433, K_AR,  K_AR};   // sub
        vecs[8]  = '{32'h123452B7, K_UI,  K_UI};   // lui
        vecs[9]  = '{32'h00001217, K_UI,  K_UI};   // auipc
        vecs[10] = '{32'h0000007F, K_ILL, K_ILL};  // unknown opcode
        vecs[11] = '{32'h022083B3, K_MUL, K_AR};   // mul

        rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; out_ready = 1'b1;
        repeat (2) tick();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_bundle", {21'd0, bundle}, 32'd0);
        chk("reset_regs", {17'd0, rd, rs1, rs2}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Decode table streamed back-to-back
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].ins;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("tbl%0d_nm_in_ready", i), {31'd0, nm_in_ready}, 32'd1);
            push_exp(vecs[i].exp, vecs[i].ins);
            tick();
            pop_check($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_nm_valid", i), {31'd0, nm_out_valid}, 32'd1);
            chk($sformatf("tbl%0d_nm_bundle", i), {21'd0, nm_bundle}, {21'd0, vecs[i].exp_nm});
            chk($sformatf("tbl%0d_nm_regs", i), {17'd0, nm_rd, nm_rs1, nm_rs2},
                {17'd0, regs_of(vecs[i].ins)});
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Load-use: one bubble, then hold until the load leaves EX
        ex_mem_read = 1'b1; ex_rd = 5'd5; in_valid = 1'b1; instr = I_ADD;
        #1;
        chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_bubble_bundle", {21'd0, bundle}, {21'd0, K_NOP});
        tick();
        chk("lu_single_bubble", {31'd0, out_valid}, 32'd0);
        chk("lu_hold_in_ready", {31'd0, in_ready}, 32'd0);
        ex_mem_read = 1'b0;
        #1;
        chk("lu_release_ready", {31'd0, in_ready}, 32'd1);
        push_exp(K_AR, I_ADD);
        tick();
        pop_check("lu_issue");
        ex_mem_read = 1'b1; ex_rd = 5'd6;
        #1;
        chk("lu_rs2_hazard", {31'd0, in_ready}, 32'd0);
        ex_rd = 5'd0; instr = I_ADDI;
        #1;
        chk("lu_rd0_no_hazard", {31'd0, in_ready}, 32'd1);
        ex_rd = 5'd5;
        #1;
        chk("lu_rs2_unused", {31'd0, in_ready}, 32'd1);
        push_exp(K_AI, I_ADDI);
        tick();
        pop_check("lu_addi");
        ex_mem_read = 1'b0; ex_rd = '0;

        // M-op hold with continuous in_valid
        instr = I_MUL;
        #1;
        push_exp(K_MUL, I_MUL);
        tick();
        pop_check("mul");
        chk("mul_nm_is_mop", {31'd0, nm_is_mop}, 32'd0);
        instr = I_ADDI;
        #1;
        chk("mul_c1_in_ready", {31'd0, in_ready}, 32'd1);
        push_exp(K_AI, I_ADDI);
        tick();
        pop_check("mul_next");
        instr = I_LW;
        #1;
        chk("mwait_in_ready1", {31'd0, in_ready}, 32'd0);
        chk("mul_nm_no_stall", {31'd0, nm_in_ready}, 32'd1);
        tick();
        chk("mwait_in_ready2", {31'd0, in_ready}, 32'd0);
        chk("mwait_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mwait_done_ready", {31'd0, in_ready}, 32'd1);
        push_exp(K_LD, I_LW);
        tick();
        pop_check("mul_after");
        in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: stalled store stays stable
        in_valid = 1'b1; instr = I_SW;
        #1;
        push_exp(K_ST, I_SW);
        tick();
        pop_check("bp_sw");
        out_ready = 1'b0; instr = I_ADDI;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_bundle", k), {21'd0, bundle}, {21'd0, K_ST});
            chk($sformatf("bp%0d_regs", k), {17'd0, rd, rs1, rs2}, {17'd0, regs_of(I_SW)});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        push_exp(K_AI, I_ADDI);
        tick();
        pop_check("bp_next");

        // Flush: during accept, with stalled bundle, and against a hazard
        instr = I_ADD; flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("fl_accept_killed", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; instr = I_ADDI;
        #1;
        push_exp(K_AI, I_ADDI);
        tick();
        pop_check("fl_pre");
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        tick();
        chk("fl_stalled_cleared", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; instr = I_ADD; ex_mem_read = 1'b1; ex_rd = 5'd5;
        tick();
        chk("fl_hazard_no_bubble", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;

        // Flush during MWAIT with cnt=2
        in_valid = 1'b1; instr = I_MUL;
        #1;
        push_exp(K_MUL, I_MUL);
        tick();
        pop_check("fm_mul");
        in_valid = 1'b0;
        tick();
        chk("fm_wait_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fm_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fm_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; instr = I_ADDI;
        #1;
        push_exp(K_AI, I_ADDI);
        tick();
        pop_check("fm_after");

        // Asynchronous reset with a stalled bundle
        instr = I_SW;
        #1;
        push_exp(K_ST, I_SW);
        tick();
        pop_check("rs_pre");
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rs_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_async_bundle", {21'd0, bundle}, 32'd0);
        chk("rs_async_regs", {17'd0, rd, rs1, rs2}, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of MWAIT
        in_valid = 1'b1; instr = I_MUL;
        #1;
        push_exp(K_MUL, I_MUL);
        tick();
        pop_check("rm_mul");
        in_valid = 1'b0;
        tick();
        chk("rm_wait_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rm_async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rm_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_async_bundle", {21'd0, bundle}, 32'd0);
        rst_n = 1'b1;
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
- Registered decode/control stage for the pipelined RISC-V core; sits between IF/ID and EX.
- Decodes the opcode into the standard control bundle and registers it with a valid/ready handshake.
- Adds load-use hazard bubbling, flush, illegal-opcode flagging, and a multi-cycle hold for M-extension ops (parametrised latency).

Parameters:
- REG_ADDR_W, 5, register index width.
- ENABLE_M, 1, 1 = decode funct7=0000001 R-type ops as MUL/DIV; 0 = treat them as plain Arith_R.
- MUL_LATENCY, 3, total EX cycles a M-op occupies (>=1); the stage holds off new issue for MUL_LATENCY-1 cycles after a M-op is accepted downstream.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid from IF/ID.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  32  instruction word.
- flush  in  1  branch/jump redirect; kill held and incoming instr.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  REG_ADDR_W  destination of instruction in EX.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  EX accepts bundle.
- can_branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, should_jump  out  1 each  control bits.
- alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type.
- is_mop  out  1  M-extension op.
- illegal  out  1  unrecognised opcode.
- rs1, rs2, rd  out  REG_ADDR_W each  instr[19:15], [24:20], [11:7].

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n). Reset clears all outputs to 0 and sets state RUN.
- Decode table (br, mr, m2r, mw, src, rw, jmp, aluop):
  - Branch: 1 0 0 0 0 0 0 01.
  - Load: 0 1 1 0 1 1 0 00.
  - Store: 0 0 0 1 1 0 0 00.
  - JAL/JALR: 0 0 0 0 1 1 1 00.
  - Arith_I: 0 0 0 0 1 1 0 11.
  - Arith_R: 0 0 0 0 0 1 0 10.
  - AUIPC/LUI: 0 0 0 0 1 1 0 00.
  - Any other opcode: all 0 and illegal=1.
- Operand use for hazard checking:
  - rs1 is used by all opcodes except JAL, AUIPC, LUI.
  - rs2 is used by Branch, Store and Arith_R.
- hazard = ex_mem_read && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)). It is combinational on the incoming instr.
- States:
  - RUN: normal issue.
  - MWAIT: counter cnt counts MUL_LATENCY-1 down to 1.
- in_ready = state==RUN && !hazard && (!out_valid || out_ready).
- Output register update, when (!out_valid || out_ready):
  - Accept (in_valid && in_ready && !flush): load the decoded bundle and set out_valid=1. Latency is 1 cycle from instr to bundle.
  - Hazard with in_valid: load a bubble (all control bits 0, out_valid=1, illegal=0) for exactly one cycle. The instr is held upstream, and in_ready rises once ex_rd changes.
  - Otherwise: out_valid=0.
- If out_valid && !out_ready, all outputs stay stable.
- M-op (ENABLE_M && Arith_R && funct7==0000001):
  - Sets is_mop=1.
  - When it is accepted downstream (out_valid && out_ready && is_mop) and MUL_LATENCY>1, go to MWAIT with cnt=MUL_LATENCY-1.
  - In MWAIT, in_ready=0 and the bubble is out_valid=0. cnt decrements each cycle; at cnt==1, return to RUN next cycle.
  - If MUL_LATENCY==1, no MWAIT is entered.
- flush:
  - Same cycle: in_ready is still computed as usual, but any accept is suppressed and out_valid is cleared next edge, even if !out_ready.
  - In MWAIT, flush returns to RUN immediately and clears cnt.
- Simultaneous flush and hazard: flush wins; no bubble is issued.
- A reset asserted mid-MWAIT or with a stalled bundle clears everything asynchronously. No pending state survives reset.
- rd/rs1/rs2 are registered alongside the bundle, and hold stale values when out_valid=0.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, alu_op=11, alu_src=1, reg_write=1, rd=1, illegal=0.
- Load-use: ex_mem_read=1, ex_rd=5, instr add x3,x5,x6 -> in_ready=0, one bubble (reg_write=0, mem_write=0). Then ex_mem_read=0 -> add issues with alu_op=10. Repeat with ex_rd=0 -> no bubble.
- mul x7,x1,x2 (0x022083B3), MUL_LATENCY=3, continuous in_valid -> is_mop=1, then in_ready=0 for 2 cycles, next instr issues on the 3rd cycle. With ENABLE_M=0 -> is_mop=0 and no stall.
- Backpressure: out_ready=0 for 4 cycles while sw is held -> bundle stable with mem_write=1, mem_read=0, in_ready=0. On release, next instr is accepted the same cycle.
- flush during an accept and during MWAIT (cnt=2) -> out_valid=0 next cycle, state RUN, in_ready=1.
- Opcode 0x7F -> illegal=1, all control bits 0. Assert rst_n=0 mid-stall -> all outputs 0 immediately, without a clock edge.
